trace_capture: RTL and testbench



---
 rtl/trace_pkg.sv | 47 ++++
 rtl/trace_fifo.sv | 72 +++++++
 rtl/trace_capture.sv | 215 +++++++++++++++++++++
 tb/tb_trace_capture.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the instruction trace capture block.
// TRACE_TIMESTAMP_EN prepends a 16-bit cycle stamp to every record.
package trace_pkg;

    localparam logic [1:0] KIND_NONE  = 2'b00;
    localparam logic [1:0] KIND_READ  = 2'b01;
    localparam logic [1:0] KIND_WRITE = 2'b10;
    localparam logic [1:0] KIND_HALT  = 2'b11;

    localparam int KIND_W = 2;
    localparam int PC_W   = 13;
    localparam int OP_W   = 3;
    localparam int IRA_W  = 13;
    localparam int DAT_W  = 8;
    localparam int TS_W   = 16;

`ifdef TRACE_TIMESTAMP_EN
    localparam int REC_W = 55;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [KIND_W-1:0] kind;
        logic [PC_W-1:0]   pc;
        logic [OP_W-1:0]   op;
        logic [IRA_W-1:0]  ira;
        logic [DAT_W-1:0]  dat;
    } trace_rec_t;
`else
    localparam int REC_W = 39;

    typedef struct packed {
        logic [KIND_W-1:0] kind;
        logic [PC_W-1:0]   pc;
        logic [OP_W-1:0]   op;
        logic [IRA_W-1:0]  ira;
        logic [DAT_W-1:0]  dat;
    } trace_rec_t;
`endif

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALTED
    } trace_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a registered head word and drop indication.
// A push into a full FIFO is only accepted when a pop frees a slot.
module trace_fifo #(
    parameter int W = 39,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [W-1:0]  dout_o,
    output logic [AW:0]   count_o,
    output logic          drop_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;
    logic [AW:0]   cnt_d;
    logic [W-1:0]  head_q, head_d;
    logic          valid_q;
    logic          full;
    logic          pop;
    logic          acc;

    assign count_o = wr_q - rd_q;
    assign full    = count_o[AW];
    assign pop     = valid_q && ready_i;
    assign acc     = push_i && (!full || pop);
    assign drop_o  = push_i && !acc;
    assign valid_o = valid_q;
    assign dout_o  = head_q;

    // Head word is forwarded from din when the new head is the slot being written.
    always_comb begin
        rd_d   = rd_q + {{AW{1'b0}}, pop};
        wr_d   = wr_q + {{AW{1'b0}}, acc};
        cnt_d  = wr_d - rd_d;
        head_d = '0;
        if (cnt_d != '0) begin
            if (acc && (rd_d[AW-1:0] == wr_q[AW-1:0])) begin
                head_d = din_i;
            end else begin
                head_d = mem_q[rd_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            head_q  <= head_d;
            valid_q <= (cnt_d != '0);
        end
    end

endmodule

// File: rtl/trace_capture.sv
// Builds one trace record per executed instruction and queues it.
// TRACE_TIMESTAMP_EN adds a free-running 16-bit cycle stamp per record.
import trace_pkg::*;

module trace_capture #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   fetch,
    input  logic [12:0]            pc_addr,
    input  logic [12:0]            ir_addr,
    input  logic [2:0]             opcode,
    input  logic [12:0]            addr,
    input  logic [7:0]             data,
    input  logic                   rd,
    input  logic                   wr,
    input  logic                   halt,
    output logic                   trc_valid,
    input  logic                   trc_ready,
    output logic [REC_W-1:0]       trc_data,
    output logic [$clog2(DEPTH):0] trc_count,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic                   halted
);

    trace_state_e      state_q, state_d;
    logic              fetch_q, halt_q;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [IRA_W-1:0]  ira_q, ira_d;
    logic [KIND_W-1:0] kind_q, kind_d, kind_c;
    logic [DAT_W-1:0]  dat_q, dat_d, dat_c;
    logic              hit_q, hit_d, hit_c;
    logic              hpend_q, hpend_d;
    logic [CNT_W-1:0]  drop_q;
    logic              fetch_rise, fetch_fall, halt_rise;
    logic              push, drop;
    trace_rec_t        pend_rec, push_rec;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts_q;
    logic [TS_W-1:0]   rts_q, rts_d;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q  <= '0;
            rts_q <= '0;
        end else begin
            ts_q  <= ts_q + 1'b1;
            rts_q <= rts_d;
        end
    end
`endif

    assign fetch_rise = fetch && !fetch_q;
    assign fetch_fall = !fetch && fetch_q;
    assign halt_rise  = halt && !halt_q;

    // A strobe seen in the closing cycle still lands in the pushed record.
    always_comb begin
        kind_c = kind_q;
        dat_c  = dat_q;
        hit_c  = hit_q;
        if ((state_q == EXEC) && !hit_q) begin
            if (wr) begin
                kind_c = KIND_WRITE;
                dat_c  = data;
                hit_c  = 1'b1;
            end else if (rd && (addr == ira_q)) begin
                kind_c = KIND_READ;
                dat_c  = data;
                hit_c  = 1'b1;
            end
        end
    end

    always_comb begin
        pend_rec      = '0;
        pend_rec.kind = kind_c;
        pend_rec.pc   = pc_q;
        pend_rec.op   = op_q;
        pend_rec.ira  = ira_q;
        pend_rec.dat  = dat_c;
`ifdef TRACE_TIMESTAMP_EN
        pend_rec.ts   = rts_q;
`endif
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        op_d     = op_q;
        ira_d    = ira_q;
        kind_d   = kind_q;
        dat_d    = dat_q;
        hit_d    = hit_q;
        hpend_d  = hpend_q;
        push     = 1'b0;
        push_rec = '0;
`ifdef TRACE_TIMESTAMP_EN
        rts_d    = rts_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (fetch_rise) begin
                    pc_d    = pc_addr;
`ifdef TRACE_TIMESTAMP_EN
                    rts_d   = ts_q;
`endif
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (halt_rise) begin
                    hpend_d = 1'b1;
                    state_d = HALTED;
                end else if (fetch_fall) begin
                    op_d    = opcode;
                    ira_d   = ir_addr;
                    kind_d  = KIND_NONE;
                    dat_d   = '0;
                    hit_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                kind_d = kind_c;
                dat_d  = dat_c;
                hit_d  = hit_c;
                if (halt_rise) begin
                    push     = 1'b1;
                    push_rec = pend_rec;
                    hpend_d  = 1'b1;
                    state_d  = HALTED;
                end else if (fetch_rise) begin
                    push     = 1'b1;
                    push_rec = pend_rec;
                    pc_d     = pc_addr;
`ifdef TRACE_TIMESTAMP_EN
                    rts_d    = ts_q;
`endif
                    state_d  = FETCH;
                end
            end
            HALTED: begin
                if (hpend_q) begin
                    push          = 1'b1;
                    push_rec.kind = KIND_HALT;
                    push_rec.pc   = pc_addr;
                    push_rec.op   = opcode;
`ifdef TRACE_TIMESTAMP_EN
                    push_rec.ts   = ts_q;
`endif
                    hpend_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fetch_q <= 1'b0;
            halt_q  <= 1'b0;
            pc_q    <= '0;
            op_q    <= '0;
            ira_q   <= '0;
            kind_q  <= KIND_NONE;
            dat_q   <= '0;
            hit_q   <= 1'b0;
            hpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch;
            halt_q  <= halt;
            pc_q    <= pc_d;
            op_q    <= op_d;
            ira_q   <= ira_d;
            kind_q  <= kind_d;
            dat_q   <= dat_d;
            hit_q   <= hit_d;
            hpend_q <= hpend_d;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_cnt = drop_q;
    assign halted   = (state_q == HALTED);

    trace_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .din_i   (push_rec),
        .ready_i (trc_ready),
        .valid_o (trc_valid),
        .dout_o  (trc_data),
        .count_o (trc_count),
        .drop_o  (drop)
    );

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture with a 4-entry FIFO.
// Checks capture, ordering, overflow, halt and async reset.
module tb_trace_capture;
    import trace_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic              sys_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fetch = 1'b0;
    logic [12:0]       pc_addr = '0;
    logic [12:0]       ir_addr = '0;
    logic [2:0]        opcode = '0;
    logic [12:0]       addr = '0;
    logic [7:0]        data = '0;
    logic              rd = 1'b0;
    logic              wr = 1'b0;
    logic              halt = 1'b0;
    logic              trc_ready = 1'b0;
    logic              trc_valid;
    logic [REC_W-1:0]  trc_data;
    logic [2:0]        trc_count;
    logic [CNT_W-1:0]  drop_cnt;
    logic              halted;

    int evals = 0;
    int fails = 0;

    trace_capture #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .fetch     (fetch),
        .pc_addr   (pc_addr),
        .ir_addr   (ir_addr),
        .opcode    (opcode),
        .addr      (addr),
        .data      (data),
        .rd        (rd),
        .wr        (wr),
        .halt      (halt),
        .trc_valid (trc_valid),
        .trc_ready (trc_ready),
        .trc_data  (trc_data),
        .trc_count (trc_count),
        .drop_cnt  (drop_cnt),
        .halted    (halted)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        evals++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [38:0] mkrec(input logic [1:0] k,
        input logic [12:0] pc, input logic [2:0] op,
        input logic [12:0] ira, input logic [7:0] d);
        return {k, pc, op, ira, d};
    endfunction

    function automatic logic [38:0] rec_i(input int i);
        return mkrec(2'b01, 13'h006 + 13'(2 * i), 3'd1,
                     13'h010 + 13'(i), 8'h20 + 8'(i));
    endfunction

    task automatic start(input logic [12:0] pc);
        fetch   = 1'b1;
        pc_addr = pc;
        tick();
    endtask

    task automatic body(input logic [2:0] op, input logic [12:0] ira,
                        input logic r, input logic w,
                        input logic [12:0] a, input logic [7:0] d);
        fetch   = 1'b0;
        opcode  = op;
        ir_addr = ira;
        tick();
        rd   = r;
        wr   = w;
        addr = a;
        data = d;
        tick();
        rd = 1'b0;
        wr = 1'b0;
        tick();
    endtask

    task automatic pop1();
        trc_ready = 1'b1;
        tick();
        trc_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", trc_valid, 1'b0);
        chk("rst_count", trc_count, 3'd0);
        chk("rst_drop", drop_cnt, 8'd0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_data", trc_data, '0);
        rst_n = 1'b1;

        // read instruction
        start(13'h002);
        body(3'd5, 13'h1801, 1'b1, 1'b0, 13'h1801, 8'h5A);
        chk("rd_valid_pre", trc_valid, 1'b0);
        start(13'h004);
        chk("rd_valid", trc_valid, 1'b1);
        chk("rd_count", trc_count, 3'd1);
        chk("rd_rec", trc_data[38:0],
            mkrec(2'b01, 13'h002, 3'd5, 13'h1801, 8'h5A));
        pop1();
        chk("rd_pop_count", trc_count, 3'd0);
        chk("rd_pop_valid", trc_valid, 1'b0);

        // write instruction, later read strobe ignored
        body(3'd6, 13'h0100, 1'b0, 1'b1, 13'h0000, 8'hC3);
        rd   = 1'b1;
        addr = 13'h0100;
        data = 8'h11;
        tick();
        rd = 1'b0;
        start(13'h006);
        chk("wr_rec", trc_data[38:0],
            mkrec(2'b10, 13'h004, 3'd6, 13'h0100, 8'hC3));
        chk("wr_count", trc_count, 3'd1);
        pop1();

        // overflow with six instructions
        for (int i = 0; i < 6; i++) begin
            body(3'd1, 13'h010 + 13'(i), 1'b1, 1'b0,
                 13'h010 + 13'(i), 8'h20 + 8'(i));
            start(13'h008 + 13'(2 * i));
        end
        chk("ovf_count", trc_count, 3'd4);
        chk("ovf_drop", drop_cnt, 8'd2);
        chk("ovf_head", trc_data[38:0], rec_i(0));

        // push into full FIFO while popping
        body(3'd1, 13'h016, 1'b1, 1'b0, 13'h016, 8'h26);
        trc_ready = 1'b1;
        start(13'h014);
        trc_ready = 1'b0;
        chk("pp_count", trc_count, 3'd4);
        chk("pp_drop", drop_cnt, 8'd2);
        for (int k = 0; k < 4; k++) begin
            chk("pp_order", trc_data[38:0], rec_i((k < 3) ? k + 1 : 6));
            pop1();
        end
        chk("pp_empty", trc_count, 3'd0);
        chk("pp_valid", trc_valid, 1'b0);

        // halt mid-EXEC
        body(3'd1, 13'h017, 1'b1, 1'b0, 13'h017, 8'h27);
        pc_addr = 13'h00A;
        opcode  = 3'd0;
        halt    = 1'b1;
        tick();
        chk("h_halted", halted, 1'b1);
        chk("h_count1", trc_count, 3'd1);
        chk("h_pend", trc_data[38:0], rec_i(7));
        tick();
        chk("h_count2", trc_count, 3'd2);
        pop1();
        chk("h_rec", trc_data[38:0],
            mkrec(2'b11, 13'h00A, 3'd0, 13'h000, 8'h00));
        pop1();
        for (int k = 0; k < 2; k++) begin
            fetch = 1'b1;
            tick();
            fetch = 1'b0;
            tick();
        end
        chk("h_norec", trc_count, 3'd0);
        chk("h_novalid", trc_valid, 1'b0);
        chk("h_stay", halted, 1'b1);
        halt = 1'b0;

        // reset mid-EXEC with three queued
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("r_unhalt", halted, 1'b0);
        chk("r_drop0", drop_cnt, 8'd0);
        for (int i = 0; i < 4; i++) begin
            start(13'h100 + 13'(2 * i));
            body(3'd2, 13'h020, 1'b1, 1'b0, 13'h020, 8'h33);
        end
        chk("r_queued", trc_count, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_valid", trc_valid, 1'b0);
        chk("r_count", trc_count, 3'd0);
        chk("r_halted", halted, 1'b0);
        chk("r_data", trc_data, '0);
        chk("r_state", dut.state_q, IDLE);
        #1;
        rst_n = 1'b1;
        tick();
        rd   = 1'b1;
        wr   = 1'b1;
        addr = 13'h020;
        tick();
        rd = 1'b0;
        wr = 1'b0;
        tick();
        chk("r_idle_cnt", trc_count, 3'd0);
        start(13'h200);
        body(3'd4, 13'h030, 1'b1, 1'b0, 13'h030, 8'h44);
        chk("r_nopush", trc_count, 3'd0);
        start(13'h202);
        chk("r_count1", trc_count, 3'd1);
        chk("r_rec", trc_data[38:0],
            mkrec(2'b01, 13'h200, 3'd4, 13'h030, 8'h44));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 evals, fails);
        $finish;
    end

endmodule
